sprite_compositor: RTL
======================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 The block SHALL have these parameters:
- NUM_SPRITES, default 2, sprite count; index 0 is highest priority.
- SPRITE_W, default 113, sprite width in pixels.
- SPRITE_H, default 157, sprite height in pixels.
- STATE_W, default 4, animation-state select width.
- NUM_STATES, default 11, count of valid states.
- PIX_W, default 8, pixel colour width.
- ROM_LAT, default 1, external ROM read latency in cycles.
- TRANSPARENT, default 8'hE3, transparent colour key.
REQ-002 ADDR_W SHALL be a localparam equal to clog2(SPRITE_W*SPRITE_H).
REQ-003 The block SHALL have these ports (per-sprite buses packed, sprite i in slice i):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- frame_start  in  1  one-cycle pulse; latches sprite attributes and the collision result.
- pix_valid_in  in  1  qualifies pixel_x/pixel_y.
- pixel_x, pixel_y  in  10 each  current raster coordinate.
- pos_x, pos_y  in  NUM_SPRITES*10 each  sprite top-left position.
- sprite_state  in  NUM_SPRITES*STATE_W  animation state.
- sprite_flip  in  NUM_SPRITES  horizontal mirror.
- sprite_en  in  NUM_SPRITES  sprite enable.
- rom_addr  out  NUM_SPRITES*ADDR_W  registered ROM address.
- rom_sel  out  NUM_SPRITES*STATE_W  registered state select for the external ROM bank mux.
- rom_data  in  NUM_SPRITES*PIX_W  ROM output, valid ROM_LAT cycles after rom_addr.
- pixel_data  out  PIX_W  composited pixel.
- pixel_valid  out  1  qualifies pixel_data.
- collision  out  1  previous frame had an opaque overlap.
- collision_mask  out  NUM_SPRITES  sprites involved in that overlap.

Function
REQ-004 On a cycle with frame_start=1, the block SHALL copy pos_x, pos_y, sprite_state, sprite_flip and sprite_en into shadow registers; all compositing SHALL use only the shadow values.
REQ-005 Stage 1 (cycle after pix_valid_in) SHALL register rom_addr, rom_sel, per-sprite hit flags and valid.
REQ-006 The hit test SHALL be done at 11-bit width so that pos+SPRITE_W or pos+SPRITE_H above 1023 does not wrap.
REQ-007 Sprite i hits when en=1, state<NUM_STATES, pos_x<=pixel_x<pos_x+SPRITE_W and pos_y<=pixel_y<pos_y+SPRITE_H.
REQ-008 With rx=pixel_x-pos_x and ry=pixel_y-pos_y, rom_addr SHALL be ry*SPRITE_W+rx when flip=0, and ry*SPRITE_W+(SPRITE_W-1-rx) when flip=1; rom_addr SHALL be 0 when the sprite does not hit.
REQ-009 Hit flags and valid SHALL be delayed ROM_LAT cycles to align with rom_data.
REQ-010 Output stage: a sprite is opaque when hit=1 and rom_data!=TRANSPARENT.
REQ-011 pixel_data SHALL be rom_data of the lowest-index opaque sprite, else TRANSPARENT; transparent pixels fall through to lower-priority sprites.
REQ-012 pixel_valid SHALL be registered, total latency pix_valid_in->pixel_valid exactly 2+ROM_LAT cycles, fully pipelined (one pixel per cycle, no stalls).
REQ-013 When pixel_valid=0, pixel_data SHALL be TRANSPARENT and no collision SHALL be accumulated.
REQ-014 Each valid output pixel with 2 or more opaque sprites SHALL set a sticky flag and OR the opaque set into a sticky mask.
REQ-015 On frame_start, collision/collision_mask SHALL load the sticky values, then the sticky values clear.
REQ-016 If a collision event coincides with frame_start, the event SHALL count toward the new frame's sticky values, not the loaded result.
REQ-017 frame_start while pixels are in flight SHALL NOT alter in-flight pixels; only pixels entering stage 1 on the next cycle or later use the new shadow values.

Reset
REQ-018 On rst=1, asynchronously:
- shadow en=0, other shadow registers 0.
- rom_addr=0, rom_sel=0, hit pipeline=0, valid pipeline=0.
- pixel_data=TRANSPARENT, pixel_valid=0.
- collision=0, collision_mask=0, sticky state 0.
REQ-019 After release, the first pixel_valid SHALL appear 2+ROM_LAT cycles after the first pix_valid_in, and all sprites stay invisible until the first frame_start.

Verification
REQ-020 Sprite0 pos(100,50) en, flip=0; pixel (100,50) -> rom_addr0=0 one cycle later; pixel (212,206) -> rom_addr0=17740; pixel (213,50) -> no hit, pixel_data=8'hE3.
REQ-021 Same setup with flip=1; pixel (100,50) -> rom_addr0=112.
REQ-022 Both sprites pos(200,100), ROM0 returns 8'hE3 and ROM1 returns 8'h1C -> pixel_data=8'h1C, no collision; ROM0 returns 8'h03 -> pixel_data=8'h03, and collision=1 with mask=2'b11 after the next frame_start.
REQ-023 pos_x=1000 at pixel_x=5 -> no hit (no wrap); state=11 -> sprite invisible.
REQ-024 Change pos between frame_start pulses -> output unaffected until the next frame_start; assert rst mid-stream -> outputs take reset values immediately without waiting for a clock edge.

Source files
------------

// File: rtl/sprite_compositor.sv
// Multi-sprite raster compositor: per-sprite hit test and ROM addressing, ROM-latency
// alignment, priority composite with colour-key transparency, and per-frame collision flags.
module sprite_compositor #(
  parameter int NUM_SPRITES = 2,
  parameter int SPRITE_W    = 113,
  parameter int SPRITE_H    = 157,
  parameter int STATE_W     = 4,
  parameter int NUM_STATES  = 11,
  parameter int PIX_W       = 8,
  parameter int ROM_LAT     = 1,
  parameter logic [PIX_W-1:0] TRANSPARENT = 8'hE3,
  localparam int ADDR_W = $clog2(SPRITE_W*SPRITE_H)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_start,
  input  logic                            pix_valid_in,
  input  logic [9:0]                      pixel_x,
  input  logic [9:0]                      pixel_y,
  input  logic [NUM_SPRITES*10-1:0]       pos_x,
  input  logic [NUM_SPRITES*10-1:0]       pos_y,
  input  logic [NUM_SPRITES*STATE_W-1:0]  sprite_state,
  input  logic [NUM_SPRITES-1:0]          sprite_flip,
  input  logic [NUM_SPRITES-1:0]          sprite_en,
  output logic [NUM_SPRITES*ADDR_W-1:0]   rom_addr,
  output logic [NUM_SPRITES*STATE_W-1:0]  rom_sel,
  input  logic [NUM_SPRITES*PIX_W-1:0]    rom_data,
  output logic [PIX_W-1:0]                pixel_data,
  output logic                            pixel_valid,
  output logic                            collision,
  output logic [NUM_SPRITES-1:0]          collision_mask
);

  logic [NUM_SPRITES*10-1:0]      sh_px_q, sh_py_q;
  logic [NUM_SPRITES*STATE_W-1:0] sh_st_q;
  logic [NUM_SPRITES-1:0]         sh_flip_q, sh_en_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_px_q   <= '0;
      sh_py_q   <= '0;
      sh_st_q   <= '0;
      sh_flip_q <= '0;
      sh_en_q   <= '0;
    end else if (frame_start) begin
      sh_px_q   <= pos_x;
      sh_py_q   <= pos_y;
      sh_st_q   <= sprite_state;
      sh_flip_q <= sprite_flip;
      sh_en_q   <= sprite_en;
    end
  end

  logic [NUM_SPRITES*ADDR_W-1:0]  addr_d, rom_addr_q;
  logic [NUM_SPRITES-1:0]         hit_d;
  logic [NUM_SPRITES*STATE_W-1:0] rom_sel_q;
  logic [ROM_LAT:0][NUM_SPRITES-1:0] hit_pipe_q;
  logic [ROM_LAT:0]               vld_pipe_q;

  // 11-bit compare keeps pos+size beyond 1023 from wrapping into a false miss
  always_comb begin
    logic [10:0] xi, yi, px, py, rx, ry, cx;
    logic [31:0] lin;
    addr_d = '0;
    hit_d  = '0;
    xi = {1'b0, pixel_x};
    yi = {1'b0, pixel_y};
    for (int i = 0; i < NUM_SPRITES; i++) begin
      px  = {1'b0, sh_px_q[i*10 +: 10]};
      py  = {1'b0, sh_py_q[i*10 +: 10]};
      rx  = xi - px;
      ry  = yi - py;
      cx  = sh_flip_q[i] ? (11'(SPRITE_W - 1) - rx) : rx;
      lin = 32'(ry) * 32'(SPRITE_W) + 32'(cx);
      hit_d[i] = pix_valid_in && sh_en_q[i] &&
                 (32'(sh_st_q[i*STATE_W +: STATE_W]) < 32'(NUM_STATES)) &&
                 (xi >= px) && (xi < px + 11'(SPRITE_W)) &&
                 (yi >= py) && (yi < py + 11'(SPRITE_H));
      if (hit_d[i]) addr_d[i*ADDR_W +: ADDR_W] = lin[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      rom_sel_q  <= '0;
      hit_pipe_q <= '0;
      vld_pipe_q <= '0;
    end else begin
      rom_addr_q    <= addr_d;
      rom_sel_q     <= sh_st_q;
      hit_pipe_q[0] <= hit_d;
      vld_pipe_q[0] <= pix_valid_in;
      for (int k = 1; k <= ROM_LAT; k++) begin
        hit_pipe_q[k] <= hit_pipe_q[k-1];
        vld_pipe_q[k] <= vld_pipe_q[k-1];
      end
    end
  end

  logic [NUM_SPRITES-1:0] opq;
  logic [PIX_W-1:0]       pix_d;
  logic                   vld_a, evt;
  logic [PIX_W-1:0]       pixel_data_q;
  logic                   pixel_valid_q, coll_q, stk_q;
  logic [NUM_SPRITES-1:0] cmask_q, stkm_q;

  assign vld_a = vld_pipe_q[ROM_LAT];

  // walk from lowest priority upward so the lowest-index opaque sprite wins
  always_comb begin
    opq   = '0;
    pix_d = TRANSPARENT;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      opq[i] = vld_a && hit_pipe_q[ROM_LAT][i] && (rom_data[i*PIX_W +: PIX_W] != TRANSPARENT);
      if (opq[i]) pix_d = rom_data[i*PIX_W +: PIX_W];
    end
  end

  assign evt = ($countones(opq) > 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_data_q  <= TRANSPARENT;
      pixel_valid_q <= 1'b0;
      coll_q        <= 1'b0;
      cmask_q       <= '0;
      stk_q         <= 1'b0;
      stkm_q        <= '0;
    end else begin
      pixel_data_q  <= pix_d;
      pixel_valid_q <= vld_a;
      if (frame_start) begin
        coll_q  <= stk_q;
        cmask_q <= stkm_q;
        stk_q   <= evt;
        stkm_q  <= evt ? opq : '0;
      end else if (evt) begin
        stk_q  <= 1'b1;
        stkm_q <= stkm_q | opq;
      end
    end
  end

  assign rom_addr       = rom_addr_q;
  assign rom_sel        = rom_sel_q;
  assign pixel_data     = pixel_data_q;
  assign pixel_valid    = pixel_valid_q;
  assign collision      = coll_q;
  assign collision_mask = cmask_q;

endmodule
